multi_timer_bank: RTL and testbench
===================================

MULTI_TIMER_BANK -- requirements
Module: multi_timer_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent stopwatch/timer channels (2..8).
REQ-002 SHALL have parameter TICKS_PER_SEC, default 1000, tick_1khz pulses per counted second (even, >=2).
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port tick_1khz  input  1  one-clk-wide timebase enable, synchronous to clk.
REQ-006 SHALL have port ch_sel  input  $clog2(NUM_CH)  channel addressed by commands and shown on outputs.
REQ-007 SHALL have port mode_sw  input  NUM_CH  per-channel mode: 1 = stopwatch (count up), 0 = timer (count down).
REQ-008 SHALL have ports start, stop, reset, inc_min, inc_sec, lap  input  1 each  one-clk command pulses applied to ch_sel.
REQ-009 SHALL have ports minutes, seconds  output  6 each  registered value of channel ch_sel.
REQ-010 SHALL have ports running, expired  output  NUM_CH each  per-channel RUN and EXPIRED state flags.
REQ-011 SHALL have port blink  output  1  flash output for expired channel ch_sel.
REQ-012 SHALL have ports lap_min, lap_sec  output  6 each; lap_valid  output  1; lap capture of channel ch_sel.

Function
REQ-013 Each channel SHALL hold a 4-state FSM: IDLE, RUN, PAUSE, EXPIRED.
REQ-014 Transitions: IDLE/PAUSE --start--> RUN; RUN --stop--> PAUSE; any --reset--> IDLE; RUN (timer) reaching 00:00 --> EXPIRED; EXPIRED --start--> ignored.
REQ-015 Command priority within one cycle: reset > stop > start > inc_min > inc_sec > lap; lower-priority commands that cycle are dropped.
REQ-016 Each channel SHALL have a prescaler counting tick_1khz only in RUN, issuing one second-step when it reaches TICKS_PER_SEC-1, then clearing; the prescaler holds in PAUSE and clears on IDLE entry.
REQ-017 Stopwatch step: seconds +1; 59 -> 0 with minutes +1; at 59:59 value saturates and the channel stays in RUN.
REQ-018 Timer step: seconds -1; 0 -> 59 with minutes -1; the step producing 00:00 SHALL move the channel to EXPIRED in the same cycle.
REQ-019 start on a timer channel at 00:00 SHALL be ignored (stays IDLE).
REQ-020 inc_min/inc_sec SHALL act only on timer channels in IDLE or PAUSE; each field +1, 59 -> 0, no carry between fields.
REQ-021 A mode_sw change on any channel SHALL force that channel to IDLE with value 00:00 and lap cleared on the next clk.
REQ-022 reset command SHALL clear the addressed channel value, prescaler, lap registers and lap_valid; other channels unaffected.
REQ-023 minutes/seconds SHALL reflect channel ch_sel with exactly 1 clk latency after any change of value or ch_sel.
REQ-024 In EXPIRED a per-channel blink phase SHALL toggle every TICKS_PER_SEC/2 ticks, starting high on entry; blink = phase of ch_sel AND expired[ch_sel], registered.
REQ-025 Stopped channels (IDLE/PAUSE/EXPIRED) SHALL never change value except via commands in REQ-020/REQ-022.

Reset
REQ-026 rst SHALL asynchronously force all channels to IDLE, values 00:00, prescalers 0, blink phases 0, lap registers 0.
REQ-027 While rst is high all outputs SHALL be 0; first command accepted on the first clk edge after rst deasserts.
REQ-028 rst asserted mid-count SHALL discard the partial second; no step is issued on release.

Configuration
REQ-029 Macro LAP_CAPTURE_EN SHALL gate lap capture.
REQ-030 With LAP_CAPTURE_EN defined: lap in RUN on a stopwatch channel copies its current value into that channel's lap registers and sets lap_valid for it; lap elsewhere is ignored; lap_min/lap_sec/lap_valid show channel ch_sel with 1 clk latency.
REQ-031 Without LAP_CAPTURE_EN: no lap registers are built, lap is ignored, lap_min/lap_sec/lap_valid are constant 0.

Verification
REQ-032 Stopwatch ch0, start, 61*TICKS_PER_SEC ticks -> minutes=1, seconds=1, running[0]=1.
REQ-033 Timer ch1, inc_min x1, inc_sec x2 (01:02), start, 62 s of ticks -> 00:00, expired[1]=1, running[1]=0, blink toggles every 500 ticks.
REQ-034 Stopwatch ch2 at 59:58, 2 s of ticks -> holds 59:59, still running; stop+start same cycle -> PAUSE.
REQ-035 Run ch0 and ch3 concurrently, reset on ch3 at 00:10 -> ch3 00:00 IDLE, ch0 continues unaffected; rst mid-second -> all 00:00, no step after release.
REQ-036 LAP_CAPTURE_EN defined: lap on ch0 at 00:07 -> lap_sec=7, lap_valid=1 while count continues; undefined -> lap outputs stay 0.

Source files
------------

// File: rtl/multi_timer_bank.sv
// multi_timer_bank: NUM_CH independent stopwatch/countdown channels sharing one
// command port, with the selected channel's value, blink and lap registered out.
// Optional lap capture is built only when the macro LAP_CAPTURE_EN is defined.

// One stopwatch/timer channel: FSM, prescaler, mm:ss value, blink phase, lap.
module mtb_channel #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode,        // 1 = stopwatch, 0 = timer
  input  logic       cmd_reset,   // commands arrive already selected and prioritized
  input  logic       cmd_stop,
  input  logic       cmd_start,
  input  logic       cmd_inc_min,
  input  logic       cmd_inc_sec,
  input  logic       cmd_lap,
  output logic [5:0] min_val,
  output logic [5:0] sec_val,
  output logic       run,
  output logic       exp,
  output logic       phase,
  output logic [5:0] lap_m,
  output logic [5:0] lap_s,
  output logic       lap_v
);
  localparam int PW = $clog2(TICKS_PER_SEC);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPD} state_t;
  state_t state, nxt;

  logic [PW-1:0] presc;
  logic [5:0]    step_min, step_sec;
  logic          mode_q, mode_vld;

  // A mode flip is only meaningful once a mode has been sampled after reset.
  logic mode_chg, timer, at_zero, tick_end, half_end, step, expiring, can_start, can_inc;
  assign mode_chg  = mode_vld && (mode != mode_q);
  assign timer     = ~mode;
  assign at_zero   = (min_val == 6'd0) && (sec_val == 6'd0);
  assign tick_end  = tick && (presc == PW'(TICKS_PER_SEC - 1));
  assign half_end  = tick && (presc == PW'(TICKS_PER_SEC / 2 - 1));
  assign step      = (state == RUN) && tick_end;
  assign expiring  = step && timer && (min_val == 6'd0) && (sec_val == 6'd1);
  assign can_start = !(timer && at_zero);
  assign can_inc   = timer && ((state == IDLE) || (state == PAUSE));

  // Track the last sampled mode to detect a switch change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= 1'b0;
      mode_vld <= 1'b0;
    end else begin
      mode_q   <= mode;
      mode_vld <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // FSM next state; expiry beats a same-cycle stop since the value already hit zero.
  always_comb begin
    nxt = state;
    if (mode_chg || cmd_reset) nxt = IDLE;
    else begin
      case (state)
        IDLE, PAUSE: if (cmd_start && can_start) nxt = RUN;
        RUN: begin
          if (expiring)      nxt = EXPD;
          else if (cmd_stop) nxt = PAUSE;
        end
        default: ;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    run = (state == RUN);
    exp = (state == EXPD);
  end

  // One-second step: stopwatch saturates at 59:59, timer borrows from minutes.
  always_comb begin
    step_min = min_val;
    step_sec = sec_val;
    if (mode) begin
      if (!((min_val == 6'd59) && (sec_val == 6'd59))) begin
        if (sec_val == 6'd59) begin
          step_sec = 6'd0;
          step_min = min_val + 6'd1;
        end else step_sec = sec_val + 6'd1;
      end
    end else begin
      if (sec_val == 6'd0) begin
        step_sec = 6'd59;
        step_min = min_val - 6'd1;
      end else step_sec = sec_val - 6'd1;
    end
  end

  // Prescaler doubles as the half-second blink timer while expired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc <= '0;
    else if (nxt == IDLE) presc <= '0;
    else if (tick && (state == RUN))  presc <= tick_end ? '0 : presc + 1'b1;
    else if (tick && (state == EXPD)) presc <= half_end ? '0 : presc + 1'b1;
  end

  // Channel value: clear, count step, or front-panel field increments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_val <= 6'd0;
      sec_val <= 6'd0;
    end else if (mode_chg || cmd_reset) begin
      min_val <= 6'd0;
      sec_val <= 6'd0;
    end else if (step) begin
      min_val <= step_min;
      sec_val <= step_sec;
    end else if (cmd_inc_min && can_inc) begin
      min_val <= (min_val == 6'd59) ? 6'd0 : min_val + 6'd1;
    end else if (cmd_inc_sec && can_inc) begin
      sec_val <= (sec_val == 6'd59) ? 6'd0 : sec_val + 6'd1;
    end
  end

  // Blink phase: high on expiry entry, toggles each half second, cleared on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 phase <= 1'b0;
    else if (nxt != EXPD)    phase <= 1'b0;
    else if (state != EXPD)  phase <= 1'b1;
    else if (half_end)       phase <= ~phase;
  end

`ifdef LAP_CAPTURE_EN
  // Lap snapshot of a running stopwatch, taken before any same-cycle step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_m <= 6'd0;
      lap_s <= 6'd0;
      lap_v <= 1'b0;
    end else if (mode_chg || cmd_reset) begin
      lap_m <= 6'd0;
      lap_s <= 6'd0;
      lap_v <= 1'b0;
    end else if (cmd_lap && (state == RUN) && mode) begin
      lap_m <= min_val;
      lap_s <= sec_val;
      lap_v <= 1'b1;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = cmd_lap;
  assign lap_m = 6'd0;
  assign lap_s = 6'd0;
  assign lap_v = 1'b0;
`endif
endmodule

// Top: command prioritization, channel array, registered view of ch_sel.
module multi_timer_bank #(
  parameter int NUM_CH        = 4,
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick_1khz,
  input  logic [$clog2(NUM_CH)-1:0] ch_sel,
  input  logic [NUM_CH-1:0]         mode_sw,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      reset,
  input  logic                      inc_min,
  input  logic                      inc_sec,
  input  logic                      lap,
  output logic [5:0]                minutes,
  output logic [5:0]                seconds,
  output logic [NUM_CH-1:0]         running,
  output logic [NUM_CH-1:0]         expired,
  output logic                      blink,
  output logic [5:0]                lap_min,
  output logic [5:0]                lap_sec,
  output logic                      lap_valid
);
  localparam int SW = $clog2(NUM_CH);

  logic [NUM_CH-1:0][5:0] ch_min, ch_sec, ch_lm, ch_ls;
  logic [NUM_CH-1:0]      ch_phase, ch_lv;
  logic [5:0]             sel_min, sel_sec, sel_lm, sel_ls;
  logic                   sel_blink, sel_lv;

  // Only the highest-priority command of a cycle survives.
  logic do_reset, do_stop, do_start, do_imin, do_isec, do_lap;
  assign do_reset = reset;
  assign do_stop  = stop    & ~reset;
  assign do_start = start   & ~(reset | stop);
  assign do_imin  = inc_min & ~(reset | stop | start);
  assign do_isec  = inc_sec & ~(reset | stop | start | inc_min);
  assign do_lap   = lap     & ~(reset | stop | start | inc_min | inc_sec);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic sel;
    assign sel = (ch_sel == SW'(g));
    mtb_channel #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick_1khz),
      .mode       (mode_sw[g]),
      .cmd_reset  (sel & do_reset),
      .cmd_stop   (sel & do_stop),
      .cmd_start  (sel & do_start),
      .cmd_inc_min(sel & do_imin),
      .cmd_inc_sec(sel & do_isec),
      .cmd_lap    (sel & do_lap),
      .min_val    (ch_min[g]),
      .sec_val    (ch_sec[g]),
      .run        (running[g]),
      .exp        (expired[g]),
      .phase      (ch_phase[g]),
      .lap_m      (ch_lm[g]),
      .lap_s      (ch_ls[g]),
      .lap_v      (ch_lv[g])
    );
  end

  // Select the addressed channel; out-of-range selects read as zero.
  always_comb begin
    sel_min   = 6'd0;
    sel_sec   = 6'd0;
    sel_lm    = 6'd0;
    sel_ls    = 6'd0;
    sel_blink = 1'b0;
    sel_lv    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == SW'(i)) begin
        sel_min   = ch_min[i];
        sel_sec   = ch_sec[i];
        sel_lm    = ch_lm[i];
        sel_ls    = ch_ls[i];
        sel_blink = ch_phase[i] & expired[i];
        sel_lv    = ch_lv[i];
      end
    end
  end

  // Registered display outputs, one clk behind value or ch_sel changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      minutes   <= 6'd0;
      seconds   <= 6'd0;
      blink     <= 1'b0;
      lap_min   <= 6'd0;
      lap_sec   <= 6'd0;
      lap_valid <= 1'b0;
    end else begin
      minutes   <= sel_min;
      seconds   <= sel_sec;
      blink     <= sel_blink;
      lap_min   <= sel_lm;
      lap_sec   <= sel_ls;
      lap_valid <= sel_lv;
    end
  end
endmodule

// File: tb/tb_multi_timer_bank.sv
// Directed bench for multi_timer_bank with a 10-tick second to keep runs short.
module tb_multi_timer_bank;
  localparam int T = 10;
  localparam logic [5:0] C_START = 6'b000001, C_STOP = 6'b000010, C_RESET = 6'b000100,
                         C_IMIN  = 6'b001000, C_ISEC = 6'b010000, C_LAP   = 6'b100000;

  logic       clk, rst, tick_1khz;
  logic [1:0] ch_sel;
  logic [3:0] mode_sw;
  logic       start, stop, reset, inc_min, inc_sec, lap;
  logic [5:0] minutes, seconds, lap_min, lap_sec;
  logic [3:0] running, expired;
  logic       blink, lap_valid;
  int checks = 0;
  int errors = 0;

  multi_timer_bank #(.NUM_CH(4), .TICKS_PER_SEC(T)) dut (
    .clk(clk), .rst(rst), .tick_1khz(tick_1khz), .ch_sel(ch_sel), .mode_sw(mode_sw),
    .start(start), .stop(stop), .reset(reset), .inc_min(inc_min), .inc_sec(inc_sec),
    .lap(lap), .minutes(minutes), .seconds(seconds), .running(running),
    .expired(expired), .blink(blink), .lap_min(lap_min), .lap_sec(lap_sec),
    .lap_valid(lap_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  // All tasks start and end on a negedge.
  task automatic pulse(input logic [1:0] ch, input logic [5:0] c);
    ch_sel = ch;
    {lap, inc_sec, inc_min, reset, stop, start} = c;
    @(negedge clk);
    {lap, inc_sec, inc_min, reset, stop, start} = 6'b0;
  endtask

  task automatic ticks(input int n);
    tick_1khz = 1'b1;
    repeat (n) @(negedge clk);
    tick_1khz = 1'b0;
  endtask

  task automatic view(input logic [1:0] ch);
    ch_sel = ch;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; tick_1khz = 1'b0; ch_sel = 2'd0; mode_sw = 4'b1101;
    {lap, inc_sec, inc_min, reset, stop, start} = 6'b0;
    repeat (2) @(negedge clk);
    checks++; if ({minutes, seconds, running, expired, blink} !== 21'd0) begin errors++;
      $display("FAIL rst_outs: got %h expected 0", {minutes, seconds, running, expired, blink}); end
    checks++; if ({lap_min, lap_sec, lap_valid} !== 13'd0) begin errors++;
      $display("FAIL rst_lap: got %h expected 0", {lap_min, lap_sec, lap_valid}); end
    rst = 1'b0;
    pulse(2'd0, C_START);
    checks++; if (running !== 4'b0001) begin errors++;
      $display("FAIL first_cmd_run: got %b expected 0001", running); end
  endtask

  task automatic test_stopwatch;
    ticks(61 * T);
    view(2'd0);
    checks++; if ({minutes, seconds} !== {6'd1, 6'd1}) begin errors++;
      $display("FAIL sw_61s: got %0d:%0d expected 1:1", minutes, seconds); end
    checks++; if (running[0] !== 1'b1) begin errors++;
      $display("FAIL sw_running: got %b expected 1", running[0]); end
    pulse(2'd0, C_RESET);
    view(2'd0);
    checks++; if ({minutes, seconds, running[0]} !== 13'd0) begin errors++;
      $display("FAIL sw_reset: got %0d:%0d run %b expected 0:0 run 0", minutes, seconds, running[0]); end
  endtask

  task automatic test_timer;
    pulse(2'd1, C_START);
    checks++; if (running[1] !== 1'b0) begin errors++;
      $display("FAIL tmr_zero_start: got %b expected 0", running[1]); end
    pulse(2'd1, C_IMIN);
    pulse(2'd1, C_ISEC);
    pulse(2'd1, C_ISEC);
    view(2'd1);
    checks++; if ({minutes, seconds} !== {6'd1, 6'd2}) begin errors++;
      $display("FAIL tmr_set: got %0d:%0d expected 1:2", minutes, seconds); end
    pulse(2'd1, C_START);
    ticks(61 * T);
    view(2'd1);
    checks++; if ({minutes, seconds, running[1], expired[1]} !== {6'd0, 6'd1, 1'b1, 1'b0}) begin errors++;
      $display("FAIL tmr_61s: got %0d:%0d run %b exp %b expected 0:1 run 1 exp 0", minutes, seconds, running[1], expired[1]); end
    ticks(T);
    view(2'd1);
    checks++; if ({minutes, seconds, running[1], expired[1]} !== {6'd0, 6'd0, 1'b0, 1'b1}) begin errors++;
      $display("FAIL tmr_expire: got %0d:%0d run %b exp %b expected 0:0 run 0 exp 1", minutes, seconds, running[1], expired[1]); end
    checks++; if (blink !== 1'b1) begin errors++;
      $display("FAIL blink_entry: got %b expected 1", blink); end
    ticks(T/2 - 1); @(negedge clk);
    checks++; if (blink !== 1'b1) begin errors++;
      $display("FAIL blink_hold: got %b expected 1", blink); end
    ticks(1); @(negedge clk);
    checks++; if (blink !== 1'b0) begin errors++;
      $display("FAIL blink_toggle_lo: got %b expected 0", blink); end
    ticks(T/2); @(negedge clk);
    checks++; if (blink !== 1'b1) begin errors++;
      $display("FAIL blink_toggle_hi: got %b expected 1", blink); end
    pulse(2'd1, C_START);
    pulse(2'd1, C_ISEC);
    view(2'd1);
    checks++; if ({expired[1], running[1], seconds} !== {1'b1, 1'b0, 6'd0}) begin errors++;
      $display("FAIL exp_ignores: got exp %b run %b sec %0d expected exp 1 run 0 sec 0", expired[1], running[1], seconds); end
    pulse(2'd1, C_RESET);
    @(negedge clk);
    checks++; if ({expired[1], blink} !== 2'b00) begin errors++;
      $display("FAIL exp_reset: got exp %b blink %b expected 0 0", expired[1], blink); end
  endtask

  task automatic test_inc;
    repeat (59) pulse(2'd1, C_ISEC);
    view(2'd1);
    checks++; if ({minutes, seconds} !== {6'd0, 6'd59}) begin errors++;
      $display("FAIL inc_59: got %0d:%0d expected 0:59", minutes, seconds); end
    pulse(2'd1, C_ISEC);
    view(2'd1);
    checks++; if ({minutes, seconds} !== {6'd0, 6'd0}) begin errors++;
      $display("FAIL inc_wrap: got %0d:%0d expected 0:0", minutes, seconds); end
    pulse(2'd1, C_IMIN | C_ISEC);
    view(2'd1);
    checks++; if ({minutes, seconds} !== {6'd1, 6'd0}) begin errors++;
      $display("FAIL inc_prio: got %0d:%0d expected 1:0", minutes, seconds); end
    pulse(2'd0, C_IMIN);
    view(2'd0);
    checks++; if ({minutes, seconds} !== {6'd0, 6'd0}) begin errors++;
      $display("FAIL inc_sw_ignored: got %0d:%0d expected 0:0", minutes, seconds); end
  endtask

  task automatic test_mode_change;
    pulse(2'd1, C_START);
    checks++; if (running[1] !== 1'b1) begin errors++;
      $display("FAIL mode_pre_run: got %b expected 1", running[1]); end
    mode_sw[1] = 1'b1;
    @(negedge clk);
    mode_sw[1] = 1'b0;
    view(2'd1);
    checks++; if ({minutes, seconds, running[1]} !== 13'd0) begin errors++;
      $display("FAIL mode_force_idle: got %0d:%0d run %b expected 0:0 run 0", minutes, seconds, running[1]); end
  endtask

  task automatic test_saturate;
    pulse(2'd2, C_START);
    ticks(3598 * T);
    view(2'd2);
    checks++; if ({minutes, seconds} !== {6'd59, 6'd58}) begin errors++;
      $display("FAIL sat_5958: got %0d:%0d expected 59:58", minutes, seconds); end
    ticks(3 * T);
    view(2'd2);
    checks++; if ({minutes, seconds, running[2]} !== {6'd59, 6'd59, 1'b1}) begin errors++;
      $display("FAIL sat_hold: got %0d:%0d run %b expected 59:59 run 1", minutes, seconds, running[2]); end
    pulse(2'd2, C_STOP | C_START);
    checks++; if (running[2] !== 1'b0) begin errors++;
      $display("FAIL stop_start_pause: got %b expected 0", running[2]); end
    pulse(2'd2, C_RESET);
    ticks(3 * T);
    view(2'd2);
    checks++; if ({minutes, seconds} !== {6'd0, 6'd0}) begin errors++;
      $display("FAIL idle_no_count: got %0d:%0d expected 0:0", minutes, seconds); end
  endtask

  task automatic test_concurrent;
    pulse(2'd0, C_START);
    pulse(2'd3, C_START);
    ticks(10 * T);
    view(2'd3);
    checks++; if ({minutes, seconds} !== {6'd0, 6'd10}) begin errors++;
      $display("FAIL conc_ch3: got %0d:%0d expected 0:10", minutes, seconds); end
    pulse(2'd3, C_RESET);
    ticks(5 * T);
    view(2'd3);
    checks++; if ({minutes, seconds, running[3]} !== 13'd0) begin errors++;
      $display("FAIL conc_ch3_reset: got %0d:%0d run %b expected 0:0 run 0", minutes, seconds, running[3]); end
    view(2'd0);
    checks++; if ({minutes, seconds, running[0]} !== {6'd0, 6'd15, 1'b1}) begin errors++;
      $display("FAIL conc_ch0: got %0d:%0d run %b expected 0:15 run 1", minutes, seconds, running[0]); end
  endtask

  task automatic test_rst_mid;
    ticks(T/2);
    rst = 1'b1;
    #1;
    checks++; if ({minutes, seconds, running, expired, blink} !== 21'd0) begin errors++;
      $display("FAIL rst_async: got %h expected 0", {minutes, seconds, running, expired, blink}); end
    @(negedge clk);
    rst = 1'b0;
    pulse(2'd0, C_START);
    ticks(T - 1);
    view(2'd0);
    checks++; if ({minutes, seconds} !== {6'd0, 6'd0}) begin errors++;
      $display("FAIL rst_partial_discard: got %0d:%0d expected 0:0", minutes, seconds); end
    ticks(1);
    view(2'd0);
    checks++; if ({minutes, seconds} !== {6'd0, 6'd1}) begin errors++;
      $display("FAIL rst_first_step: got %0d:%0d expected 0:1", minutes, seconds); end
  endtask

  task automatic test_lap;
    logic [5:0] exp_ls;
    logic       exp_lv;
`ifdef LAP_CAPTURE_EN
    exp_ls = 6'd7; exp_lv = 1'b1;
`else
    exp_ls = 6'd0; exp_lv = 1'b0;
`endif
    pulse(2'd0, C_RESET);
    pulse(2'd0, C_START);
    ticks(7 * T);
    pulse(2'd0, C_LAP);
    view(2'd0);
    checks++; if ({lap_min, lap_sec, lap_valid} !== {6'd0, exp_ls, exp_lv}) begin errors++;
      $display("FAIL lap_capture: got %0d:%0d v %b expected 0:%0d v %b", lap_min, lap_sec, lap_valid, exp_ls, exp_lv); end
    ticks(3 * T);
    view(2'd0);
    checks++; if ({seconds, lap_sec, running[0]} !== {6'd10, exp_ls, 1'b1}) begin errors++;
      $display("FAIL lap_continue: got sec %0d lap %0d run %b expected 10 %0d 1", seconds, lap_sec, running[0], exp_ls); end
    pulse(2'd0, C_STOP);
    ticks(2 * T);
    pulse(2'd0, C_LAP);
    view(2'd0);
    checks++; if ({seconds, lap_sec} !== {6'd10, exp_ls}) begin errors++;
      $display("FAIL lap_paused_ignored: got sec %0d lap %0d expected 10 %0d", seconds, lap_sec, exp_ls); end
    pulse(2'd0, C_RESET);
    view(2'd0);
    checks++; if ({lap_min, lap_sec, lap_valid} !== 13'd0) begin errors++;
      $display("FAIL lap_reset: got %0d:%0d v %b expected 0:0 v 0", lap_min, lap_sec, lap_valid); end
  endtask

  initial begin
    test_reset;
    test_stopwatch;
    test_timer;
    test_inc;
    test_mode_change;
    test_saturate;
    test_concurrent;
    test_rst_mid;
    test_lap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
